sig_monitor: RTL and testbench

SIG_MONITOR -- requirements
Module: sig_monitor

---
 rtl/sig_monitor.sv | 148 ++++++++++++++
 tb/tb_sig_monitor.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sig_monitor.sv
// rtl/sig_monitor.sv - traffic-light signal monitor: phase tracking, dwell/sequence/starvation checks
module sig_monitor #(
  parameter int Y_CYCLES  = 3,
  parameter int AR_CYCLES = 2,
  parameter int MAX_WAIT  = 20
) (
  input  logic       clock,
  input  logic       clear,
  input  logic [1:0] hwy,
  input  logic [1:0] cntry,
  input  logic       x,
  output logic [2:0] phase,
  output logic       err_code,
  output logic       err_conflict,
  output logic       err_seq,
  output logic       err_timing,
  output logic       err_starve,
  output logic       err_sticky,
  output logic [7:0] grant_cnt
);

  localparam logic [2:0] P_INIT = 3'd0;
  localparam logic [2:0] P_HG   = 3'd1;
  localparam logic [2:0] P_HY   = 3'd2;
  localparam logic [2:0] P_AR   = 3'd3;
  localparam logic [2:0] P_CG   = 3'd4;
  localparam logic [2:0] P_CY   = 3'd5;
  localparam logic [2:0] C_ILL  = 3'd7;

  localparam logic [7:0] Y_MIN   = 8'(Y_CYCLES);
  localparam logic [7:0] Y_OVER  = 8'(Y_CYCLES + 1);
  localparam logic [7:0] AR_MIN  = 8'(AR_CYCLES);
  localparam logic [7:0] AR_OVER = 8'(AR_CYCLES + 1);
  localparam logic [7:0] ST_LIM  = 8'(MAX_WAIT + 1);

  logic [2:0] r_phase;
  logic [7:0] r_dwell;
  logic [7:0] r_starve;
  logic [7:0] r_grant;
  logic       r_x_d;
  logic       r_err_code, r_err_conflict, r_err_seq, r_err_timing, r_err_starve, r_sticky;

  logic [2:0] w_combo;
  logic [2:0] w_phase_nxt;
  logic [7:0] w_dwell_nxt;
  logic [7:0] w_starve_nxt;
  logic       w_stay, w_legal_step, w_leave, w_yellow, w_any_code3;
  logic       w_code, w_conflict, w_seq, w_timing, w_starve, w_grant_inc;

  always_comb begin
    case ({hwy, cntry})
      4'b1000: w_combo = P_HG;
      4'b0100: w_combo = P_HY;
      4'b0000: w_combo = P_AR;
      4'b0010: w_combo = P_CG;
      4'b0001: w_combo = P_CY;
      default: w_combo = C_ILL;
    endcase
  end

  assign w_stay       = (w_combo == r_phase);
  assign w_yellow     = (r_phase == P_HY) || (r_phase == P_CY);
  assign w_any_code3  = (hwy == 2'd3) || (cntry == 2'd3);
  assign w_legal_step = ((r_phase == P_HG) && (w_combo == P_HY)) ||
                        ((r_phase == P_HY) && (w_combo == P_AR)) ||
                        ((r_phase == P_AR) && (w_combo == P_CG)) ||
                        ((r_phase == P_CG) && (w_combo == P_CY)) ||
                        ((r_phase == P_CY) && (w_combo == P_HG));

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_phase        <= P_INIT;
      r_dwell        <= 8'd0;
      r_starve       <= 8'd0;
      r_grant        <= 8'd0;
      r_x_d          <= 1'b0;
      r_err_code     <= 1'b0;
      r_err_conflict <= 1'b0;
      r_err_seq      <= 1'b0;
      r_err_timing   <= 1'b0;
      r_err_starve   <= 1'b0;
      r_sticky       <= 1'b0;
    end else begin
      r_phase        <= w_phase_nxt;
      r_dwell        <= w_dwell_nxt;
      r_starve       <= w_starve_nxt;
      r_x_d          <= x;
      r_err_code     <= w_code;
      r_err_conflict <= w_conflict;
      r_err_seq      <= w_seq;
      r_err_timing   <= w_timing;
      r_err_starve   <= w_starve;
      r_sticky       <= r_sticky | w_code | w_conflict | w_seq | w_timing | w_starve;
      if (w_grant_inc && (r_grant != 8'hFF)) r_grant <= r_grant + 8'd1;
    end
  end

  always_comb begin
    w_phase_nxt  = r_phase;
    w_dwell_nxt  = r_dwell;
    w_starve_nxt = 8'd0;
    if (r_phase == P_INIT) begin
      if (w_combo == P_HG) begin
        w_phase_nxt = P_HG;
        w_dwell_nxt = 8'd1;
      end
    end else if (w_combo == C_ILL) begin
      w_phase_nxt = P_INIT;
      w_dwell_nxt = 8'd0;
    end else if (w_stay) begin
      if (r_dwell != 8'hFF) w_dwell_nxt = r_dwell + 8'd1;
    end else begin
      w_phase_nxt = w_combo;
      w_dwell_nxt = 8'd1;
    end
    // starvation run restarts from zero whenever HG is (re)entered
    if ((w_phase_nxt == P_HG) && x) begin
      if (r_phase != P_HG)         w_starve_nxt = 8'd1;
      else if (r_starve != 8'hFF)  w_starve_nxt = r_starve + 8'd1;
      else                         w_starve_nxt = r_starve;
    end
  end

  always_comb begin
    w_leave     = (r_phase != P_INIT) && (w_phase_nxt != r_phase);
    w_code      = (r_phase != P_INIT) && (w_combo == C_ILL) && w_any_code3;
    w_conflict  = (r_phase != P_INIT) && (w_combo == C_ILL) && !w_any_code3;
    w_seq       = (r_phase != P_INIT) && (w_combo != C_ILL) && !w_stay &&
                  (!w_legal_step || ((r_phase == P_HG) && !r_x_d));
    w_timing    = (w_leave && ((w_yellow && (r_dwell < Y_MIN)) ||
                               ((r_phase == P_AR) && (r_dwell < AR_MIN)))) ||
                  ((r_phase != P_INIT) && w_stay &&
                   ((w_yellow && (w_dwell_nxt == Y_OVER) && (r_dwell != Y_OVER)) ||
                    ((r_phase == P_AR) && (w_dwell_nxt == AR_OVER) && (r_dwell != AR_OVER))));
    w_starve    = (w_starve_nxt == ST_LIM) && (r_starve != ST_LIM);
    w_grant_inc = (r_phase == P_AR) && (w_combo == P_CG);
  end

  assign phase        = r_phase;
  assign err_code     = r_err_code;
  assign err_conflict = r_err_conflict;
  assign err_seq      = r_err_seq;
  assign err_timing   = r_err_timing;
  assign err_starve   = r_err_starve;
  assign err_sticky   = r_sticky;
  assign grant_cnt    = r_grant;

endmodule

// File: tb/tb_sig_monitor.sv
// tb/tb_sig_monitor.sv - directed and randomized bench for sig_monitor against a rule-level model
module tb_sig_monitor;
  localparam int YC  = 3;
  localparam int ARC = 2;
  localparam int MW  = 20;

  logic       clock = 1'b0;
  logic       clear;
  logic [1:0] hwy, cntry;
  logic       x;
  logic [2:0] phase;
  logic       err_code, err_conflict, err_seq, err_timing, err_starve, err_sticky;
  logic [7:0] grant_cnt;

  sig_monitor #(.Y_CYCLES(YC), .AR_CYCLES(ARC), .MAX_WAIT(MW)) dut (
    .clock(clock), .clear(clear), .hwy(hwy), .cntry(cntry), .x(x),
    .phase(phase), .err_code(err_code), .err_conflict(err_conflict),
    .err_seq(err_seq), .err_timing(err_timing), .err_starve(err_starve),
    .err_sticky(err_sticky), .grant_cnt(grant_cnt)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference state: phase numbers 0..5, combo -1 = illegal
  int  m_phase, m_dwell, m_starve, m_grant;
  bit  m_prev_x, m_sticky;
  bit  e_code, e_conf, e_seq, e_tim, e_stv;
  int  succ [6] = '{0, 2, 3, 4, 5, 1};
  logic [1:0] code_h [6] = '{2'd0, 2'd2, 2'd1, 2'd0, 2'd0, 2'd0};
  logic [1:0] code_c [6] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd1};

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int dwell_lim(input int p);
    if (p == 2 || p == 5) return YC;
    if (p == 3) return ARC;
    return 0;
  endfunction

  function automatic int decode(input logic [1:0] h, input logic [1:0] c);
    for (int p = 1; p < 6; p++)
      if (h == code_h[p] && c == code_c[p]) return p;
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_dwell = 0; m_starve = 0; m_grant = 0;
    m_prev_x = 0; m_sticky = 0;
    e_code = 0; e_conf = 0; e_seq = 0; e_tim = 0; e_stv = 0;
  endtask

  task automatic model_step(input logic [1:0] h, input logic [1:0] c, input logic xv);
    int combo, old, old_dwell, prev;
    combo = decode(h, c); old = m_phase; old_dwell = m_dwell;
    e_code = 0; e_conf = 0; e_seq = 0; e_tim = 0; e_stv = 0;
    if (old == 0) begin
      if (combo == 1) begin m_phase = 1; m_dwell = 1; end
    end else if (combo < 0) begin
      if (h == 2'd3 || c == 2'd3) e_code = 1; else e_conf = 1;
      m_phase = 0; m_dwell = 0;
    end else if (combo == old) begin
      if (m_dwell < 255) m_dwell++;
      if (dwell_lim(old) > 0 && m_dwell == dwell_lim(old) + 1 && old_dwell != m_dwell) e_tim = 1;
    end else begin
      if (combo != succ[old] || (old == 1 && !m_prev_x)) e_seq = 1;
      if (old == 3 && combo == 4 && m_grant < 255) m_grant++;
      m_phase = combo; m_dwell = 1;
    end
    if (old != 0 && m_phase != old && old_dwell < dwell_lim(old)) e_tim = 1;
    if (m_phase == 1 && xv) begin
      prev = (old == 1) ? m_starve : 0;
      m_starve = (prev < 255) ? prev + 1 : 255;
      if (m_starve == MW + 1 && prev != MW + 1) e_stv = 1;
    end else begin
      m_starve = 0;
    end
    m_prev_x = xv;
    m_sticky = m_sticky | e_code | e_conf | e_seq | e_tim | e_stv;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".phase"},    8'(phase),        8'(m_phase));
    check({tag, ".code"},     8'(err_code),     8'(e_code));
    check({tag, ".conflict"}, 8'(err_conflict), 8'(e_conf));
    check({tag, ".seq"},      8'(err_seq),      8'(e_seq));
    check({tag, ".timing"},   8'(err_timing),   8'(e_tim));
    check({tag, ".starve"},   8'(err_starve),   8'(e_stv));
    check({tag, ".sticky"},   8'(err_sticky),   8'(m_sticky));
    check({tag, ".grant"},    grant_cnt,        8'(m_grant));
  endtask

  task automatic step(input logic [1:0] h, input logic [1:0] c, input logic xv, input string tag);
    hwy = h; cntry = c; x = xv;
    @(posedge clock);
    model_step(h, c, xv);
    #1;
    check_outputs(tag);
  endtask

  task automatic put(input int p, input logic xv, input int n, input string tag);
    for (int i = 0; i < n; i++) step(code_h[p], code_c[p], xv, tag);
  endtask

  // Called one time unit after a rising edge; the pulse sits between edges.
  task automatic do_reset(input string tag);
    #2 clear = 1'b0;
    #1;
    check({tag, ".phase"},  8'(phase), 8'd0);
    check({tag, ".errs"},   8'({err_code, err_conflict, err_seq, err_timing, err_starve}), 8'd0);
    check({tag, ".sticky"}, 8'(err_sticky), 8'd0);
    check({tag, ".grant"},  grant_cnt, 8'd0);
    model_reset();
    #2 clear = 1'b1;
  endtask

  task automatic clean_cycle(input string tag);
    put(1, 1'b1, 1, tag);
    put(2, 1'b0, YC, tag);
    put(3, 1'b0, ARC, tag);
    put(4, 1'b0, 1, tag);
    put(5, 1'b0, YC, tag);
  endtask

  initial begin
    int r, p;
    logic xv;
    clear = 1'b0; hwy = 2'd0; cntry = 2'd0; x = 1'b0;
    model_reset();
    @(posedge clock); #1;
    do_reset("reset0");

    // clean cycle ending back in HG
    clean_cycle("clean");
    put(1, 1'b1, 1, "clean_end");
    check("clean.no_err", 8'(err_sticky), 8'd0);
    check("clean.grant1", grant_cnt, 8'd1);
    check("clean.phase_hg", 8'(phase), 8'd1);

    // short yellow, then long yellow
    put(2, 1'b0, 2, "hy_short");
    put(3, 1'b0, 1, "ar_after_short");
    check("hy_short.timing", 8'(err_timing), 8'd1);
    put(3, 1'b0, 1, "ar2");
    put(4, 1'b0, 1, "cg");
    put(5, 1'b0, YC, "cy");
    put(1, 1'b1, 1, "hg");
    put(2, 1'b0, 3, "hy_long_a");
    put(2, 1'b0, 1, "hy_long_4th");
    check("hy_long.timing", 8'(err_timing), 8'd1);
    put(2, 1'b0, 1, "hy_long_5th");
    check("hy_long.no_repeat", 8'(err_timing), 8'd0);
    put(3, 1'b0, ARC, "ar_after_long");

    // out-of-order jump, then conflict
    put(4, 1'b0, 1, "cg_x");
    put(5, 1'b0, YC, "cy_x");
    put(1, 1'b1, 1, "hg_x");
    put(4, 1'b0, 1, "hg_to_cg");
    check("jump.seq", 8'(err_seq), 8'd1);
    check("jump.phase", 8'(phase), 8'd4);
    step(2'd2, 2'd1, 1'b0, "conflict");
    check("conflict.pulse", 8'(err_conflict), 8'd1);
    check("conflict.phase", 8'(phase), 8'd0);
    check("conflict.sticky", 8'(err_sticky), 8'd1);

    // starvation
    @(posedge clock); #1;
    do_reset("reset1");
    put(1, 1'b1, MW + 1, "starve_a");
    check("starve.pulse", 8'(err_starve), 8'd1);
    put(1, 1'b1, 3, "starve_hold");
    put(1, 1'b0, 1, "starve_x0");
    put(1, 1'b1, MW, "starve_b");
    check("starve.no_early", 8'(err_sticky), 8'd1);
    put(1, 1'b1, 1, "starve_b21");
    check("starve.again", 8'(err_starve), 8'd1);

    // illegal code during CG, then reset mid-CY
    put(2, 1'b0, YC, "p_hy");
    put(3, 1'b0, ARC, "p_ar");
    put(4, 1'b0, 1, "p_cg");
    step(2'd3, 2'd2, 1'b0, "code3");
    check("code3.pulse", 8'(err_code), 8'd1);
    check("code3.phase", 8'(phase), 8'd0);
    put(1, 1'b1, 1, "re_hg");
    put(2, 1'b0, YC, "re_hy");
    put(3, 1'b0, ARC, "re_ar");
    put(4, 1'b0, 1, "re_cg");
    put(5, 1'b0, 1, "re_cy");
    do_reset("reset_mid_cy");

    // resumes in INIT, quiet until HG
    put(5, 1'b0, 2, "post_cy");
    put(3, 1'b0, 1, "post_ar");
    step(2'd3, 2'd3, 1'b1, "post_ill");
    put(4, 1'b0, 1, "post_cg");
    check("post.quiet", 8'(err_sticky), 8'd0);
    put(1, 1'b1, 1, "post_hg");
    check("post.phase_hg", 8'(phase), 8'd1);

    // grant saturation
    @(posedge clock); #1;
    do_reset("reset2");
    for (int i = 0; i < 256; i++) clean_cycle("sat");
    check("sat.grant255", grant_cnt, 8'd255);

    // randomized walk biased towards legal sequencing
    @(posedge clock); #1;
    do_reset("reset3");
    for (int i = 0; i < 3000; i++) begin
      r  = $urandom_range(0, 99);
      xv = ($urandom_range(0, 3) != 0);
      if (r < 40)      p = (m_phase == 0) ? 1 : succ[m_phase];
      else if (r < 78) p = (m_phase == 0) ? 1 : m_phase;
      else if (r < 92) p = $urandom_range(1, 5);
      else             p = -1;
      if (p < 0) step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), xv, "rand_raw");
      else       put(p, xv, 1, "rand");
      if (i % 1000 == 999) do_reset("rand_reset");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
